fir_output_decimator: RTL and testbench

FIR_OUTPUT_DECIMATOR -- requirements
Module: fir_output_decimator

---
 rtl/fir_output_decimator_pkg.sv | 16 +
 rtl/fir_output_decimator_sync_fifo.sv | 64 ++++++
 rtl/fir_output_decimator.sv | 90 +++++++++
 tb/tb_fir_output_decimator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_output_decimator_pkg.sv
// Shared FIR parameter defaults and small helpers for the FIR datapath blocks.
package fir_output_decimator_pkg;

  // Defaults shared with filter and FIR_filter.
  localparam int unsigned FIR_NUM_BITS    = 8;
  localparam int unsigned FIR_OUTPUT_SIZE = 2 * FIR_NUM_BITS + 1;
  localparam int unsigned FIR_DECIM       = 4;
  localparam int unsigned FIR_OUT_WIDTH   = 10;
  localparam int unsigned FIR_FIFO_DEPTH  = 8;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_output_decimator_sync_fifo.sv
// Registered-output synchronous FIFO. Head is read straight from storage, so a
// written entry only becomes visible after the write edge (no fall-through).
module sync_fifo
  import fir_output_decimator_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int unsigned PW   = idx_width(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             full, pop, accept;

  // Full FIFO still accepts a write when the head is popped on the same edge.
  always_comb begin
    full     = (count_q == CNTW'(DEPTH));
    pop      = rd_ready && (count_q != '0);
    accept   = wr_en && (!full || pop);
    drop     = wr_en && full && !pop;
    rd_data  = mem_q[rd_ptr_q];
    rd_valid = (count_q != '0);
    count    = count_q;
  end

  // Storage, pointers (modulo DEPTH) and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_output_decimator.sv
// Boxcar decimator on the filter output: averages DECIM samples, rounds
// half-up to OUT_WIDTH with saturation and queues results in a FIFO.
module fir_output_decimator
  import fir_output_decimator_pkg::*;
#(
  parameter int unsigned num_bits    = FIR_NUM_BITS,
  parameter int unsigned output_size = 2 * num_bits + 1,
  parameter int unsigned DECIM       = FIR_DECIM,
  parameter int unsigned OUT_WIDTH   = FIR_OUT_WIDTH,
  parameter int unsigned FIFO_DEPTH  = FIR_FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [output_size-1:0]        data_in,
  input  logic                          enable,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int unsigned LOG2D = $clog2(DECIM);
  localparam int unsigned CW    = idx_width(DECIM);
  localparam int unsigned AW    = output_size + LOG2D;
  localparam int unsigned SH    = output_size - OUT_WIDTH;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          acc_q, acc_d, sum;
  logic [output_size-1:0] avg;
  logic [output_size:0]   rounded;
  logic [OUT_WIDTH:0]     shifted;
  logic [OUT_WIDTH-1:0]   reduced;
  logic                   last, push, drop;
  logic                   overflow_q, overflow_d;

  // Window sum, average and half-up rounding with saturation on carry-out.
  always_comb begin
    last    = (cnt_q == CW'(DECIM - 1));
    sum     = acc_q + AW'(data_in);
    avg     = output_size'(sum >> LOG2D);
    rounded = {1'b0, avg} + ((output_size + 1)'(1) << (SH - 1));
    shifted = (OUT_WIDTH + 1)'(rounded >> SH);
    reduced = shifted[OUT_WIDTH] ? '1 : shifted[OUT_WIDTH-1:0];
    push    = enable && last;
  end

  // Next window state; disabling discards any partial window.
  always_comb begin
    cnt_d      = '0;
    acc_d      = '0;
    overflow_d = (overflow_q && !clear_ovf) || drop;
    if (enable) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
      acc_d = (cnt_q == '0) ? AW'(data_in) : sum;
    end
  end

  // Window counter, accumulator and sticky overflow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (reduced),
    .rd_ready (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (fifo_count),
    .drop     (drop)
  );

endmodule

// File: tb/tb_fir_output_decimator.sv
// Self-checking bench for fir_output_decimator: constant-window table, FIFO
// fill/overflow sequences, mid-window reset and randomized lockstep checking.
module tb_fir_output_decimator;

  localparam int unsigned NB    = 8;
  localparam int unsigned OS    = 17;
  localparam int unsigned DECIM = 4;
  localparam int unsigned OW    = 10;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [OS-1:0]   data_in = '0;
  logic            enable = 1'b0;
  logic [OW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CNTW-1:0] fifo_count;
  logic            overflow;
  logic            clear_ovf = 1'b0;

  int tests = 0;
  int fails = 0;

  // Reference model state: samples of the open window, queued outputs, flag.
  int win[$];
  int mfifo[$];
  bit movf;

  fir_output_decimator #(
    .num_bits    (NB),
    .output_size (OS),
    .DECIM       (DECIM),
    .OUT_WIDTH   (OW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .enable     (enable),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  always #500 clock = ~clock;

  initial begin
    #50ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mean of a window, rounded half-up to OW bits, clipped at full scale.
  function automatic int ref_reduce(input int s);
    int avg, r;
    avg = s / DECIM;
    r   = (avg + (1 << (OS - OW - 1))) / (1 << (OS - OW));
    if (r > (1 << OW) - 1) r = (1 << OW) - 1;
    return r;
  endfunction

  task automatic model_reset();
    win.delete();
    mfifo.delete();
    movf = 1'b0;
  endtask

  task automatic model_edge(input int d, input bit en, input bit rdy, input bit clr);
    bit pop, full, have, drop;
    int s, val, tmp;
    have = 1'b0;
    drop = 1'b0;
    val  = 0;
    pop  = rdy && (mfifo.size() > 0);
    full = (mfifo.size() == DEPTH);
    if (en) begin
      win.push_back(d);
      if (win.size() == DECIM) begin
        s = 0;
        foreach (win[i]) s += win[i];
        val  = ref_reduce(s);
        have = 1'b1;
        win.delete();
      end
    end else begin
      win.delete();
    end
    if (pop) tmp = mfifo.pop_front();
    if (have) begin
      if (!full || pop) mfifo.push_back(val);
      else drop = 1'b1;
    end
    movf = (movf && !clr) || drop;
  endtask

  task automatic compare_outputs();
    chk("out_valid", out_valid, mfifo.size() != 0);
    if (mfifo.size() != 0) chk("out_data", out_data, mfifo[0]);
    chk("fifo_count", fifo_count, mfifo.size());
    chk("overflow", overflow, movf);
  endtask

  // One clock: model follows the inputs seen at the edge, outputs checked #1 later.
  task automatic tick();
    int d;
    bit en, rdy, clr;
    d   = int'(data_in);
    en  = enable;
    rdy = out_ready;
    clr = clear_ovf;
    @(posedge clock);
    model_edge(d, en, rdy, clr);
    #1;
    compare_outputs();
    @(negedge clock);
  endtask

  task automatic drive(input int d, input bit en, input bit rdy, input bit clr);
    data_in   = OS'(d);
    enable    = en;
    out_ready = rdy;
    clear_ovf = clr;
  endtask

  task automatic run_window(input int base, input int stp, input bit rdy, input bit rdy_last);
    for (int i = 0; i < int'(DECIM); i++) begin
      drive(base + i * stp, 1'b1, (i == int'(DECIM) - 1) ? rdy_last : rdy, 1'b0);
      tick();
    end
  endtask

  typedef struct {
    int din;
    int exp;
  } vec_t;

  vec_t vecs[8];
  int   exp_q[$];

  initial begin
    vecs[0] = '{din: 4096,   exp: 32};
    vecs[1] = '{din: 63,     exp: 0};
    vecs[2] = '{din: 64,     exp: 1};
    vecs[3] = '{din: 131071, exp: 1023};
    vecs[4] = '{din: 0,      exp: 0};
    vecs[5] = '{din: 8192,   exp: 64};
    vecs[6] = '{din: 191,    exp: 1};
    vecs[7] = '{din: 192,    exp: 2};

    // Reset state.
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_fifo_count", fifo_count, 0);
    chk("reset_overflow", overflow, 0);
    reset = 1'b1;
    @(negedge clock);

    // Constant windows against hand-computed results, consumer always ready.
    foreach (vecs[v]) begin
      for (int i = 0; i < int'(DECIM); i++) begin
        drive(vecs[v].din, 1'b1, 1'b1, 1'b0);
        tick();
        if (i < int'(DECIM) - 1) chk("table_early_valid", out_valid, 0);
      end
      chk("table_valid", out_valid, 1);
      chk("table_out", out_data, vecs[v].exp);
      chk("table_count", fifo_count, 1);
      chk("table_ovf", overflow, 0);
    end
    drive(0, 1'b0, 1'b1, 1'b0);
    tick();

    // Nine windows with the consumer stalled: ninth is dropped.
    exp_q.delete();
    for (int w = 0; w < 9; w++) begin
      run_window(5000 * w + 100, 300, 1'b0, 1'b0);
      if (w < 8) exp_q.push_back(((5000 * w + 100) * 4 + 1800) / 4 / 128 +
                                 ((((5000 * w + 100) * 4 + 1800) / 4 % 128) >= 64));
      if (w == 7) begin
        chk("fill_count", fifo_count, 8);
        chk("fill_ovf", overflow, 0);
      end
    end
    chk("ovf_count", fifo_count, 8);
    chk("ovf_set", overflow, 1);
    for (int k = 0; k < 8; k++) begin
      chk("drain_order", out_data, exp_q[k]);
      drive(0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("drain_empty", fifo_count, 0);
    chk("ovf_sticky", overflow, 1);
    drive(0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ovf_cleared", overflow, 0);

    // Full FIFO, ninth push lands on the same edge as a pop.
    for (int w = 0; w < 8; w++) run_window(3000 * w + 50, 200, 1'b0, 1'b0);
    run_window(40000, 1000, 1'b0, 1'b1);
    chk("pushpop_count", fifo_count, 8);
    chk("pushpop_ovf", overflow, 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("pushpop_drained", fifo_count, 0);

    // Reset two samples into a window; pre-reset data must not reappear.
    drive(131071, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    #100;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_ovf", overflow, 0);
    @(negedge clock);
    reset = 1'b1;
    drive(4096, 1'b1, 1'b1, 1'b0);
    tick();
    chk("post_rst_valid1", out_valid, 0);
    tick();
    chk("post_rst_valid2", out_valid, 0);
    drive(8192, 1'b1, 1'b1, 1'b0);
    tick();
    chk("post_rst_valid3", out_valid, 0);
    tick();
    chk("post_rst_valid4", out_valid, 1);
    chk("post_rst_data", out_data, 48);

    // Randomized traffic: slow consumer first, then a mostly-ready one.
    for (int c = 0; c < 600; c++) begin
      drive(int'($urandom_range(0, (1 << OS) - 1)),
            $urandom_range(0, 15) != 0,
            (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
